// File: rtl/ripple_mon_pkg.sv
// Shared types and constants for the ripple counter monitor.
package ripple_mon_pkg;

   localparam int unsigned EXT_W_DEFAULT = 12;
   localparam int unsigned CNT_W         = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      MATCH = 2'd2
   } mon_state_t;

endpackage

// File: rtl/ripple_count_monitor_sync.sv
// Synchronizer and ripple filter for the asynchronous 4-bit ripple counter.
module ripple_sync_filter
   import ripple_mon_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] cnt_in,
   output logic [CNT_W-1:0] acc_out,
   output logic             acc_upd
);

   logic [CNT_W-1:0] s1;
   logic [CNT_W-1:0] s2;
   logic [CNT_W-1:0] s3;
   logic [CNT_W-1:0] acc;

   // acc_out/acc_upd are the acc register's D input and load strobe, so the
   // parent can extend the count on the same edge that acc changes.
   always_comb begin
      acc_upd = (s2 == s3) && (s2 != acc);
      acc_out = acc_upd ? s2 : acc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1  <= '0;
         s2  <= '0;
         s3  <= '0;
         acc <= '0;
      end else begin
         s1  <= cnt_in;
         s2  <= s1;
         s3  <= s2;
         acc <= acc_out;
      end
   end

endmodule

// File: rtl/ripple_count_monitor.sv
// Extends a filtered ripple count and raises a handshaked event at a threshold.
module ripple_count_monitor
   import ripple_mon_pkg::*;
#(
   parameter int unsigned EXT_W = EXT_W_DEFAULT
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             arm,
   input  logic [EXT_W-1:0] thresh,
   output logic [EXT_W-1:0] ext_count,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [EXT_W-1:0] evt_count,
   output logic             overflow,
   output logic             skip_err,
   output logic [1:0]       state
);

   localparam int unsigned HI_W = EXT_W - CNT_W;

   logic [CNT_W-1:0] acc_next;
   logic             acc_upd;
   logic [EXT_W-1:0] ext_q;
   logic [EXT_W-1:0] ext_d;
   logic [EXT_W-1:0] thr_q;
   logic [EXT_W-1:0] evt_q;
   logic [HI_W:0]    hi_sum;
   logic             carry;
   logic             wrap;
   logic             step_bad;
   logic             ovf_q;
   logic             skip_q;
   logic             arm_q;
   logic             arm_rise;
   logic             arm_load;
   logic             match_load;
   mon_state_t       state_q;
   mon_state_t       state_d;

   ripple_sync_filter u_filter (
      .clk     (clk),
      .reset   (reset),
      .cnt_in  (cnt_in),
      .acc_out (acc_next),
      .acc_upd (acc_upd)
   );

   // Upper bits count low-nibble wraps; carry out of them is the overflow.
   always_comb begin
      carry    = acc_upd && (acc_next < ext_q[CNT_W-1:0]);
      hi_sum   = {1'b0, ext_q[EXT_W-1:CNT_W]} + (HI_W+1)'(carry);
      ext_d    = {hi_sum[HI_W-1:0], acc_next};
      wrap     = hi_sum[HI_W];
      step_bad = acc_upd && (acc_next != ext_q[CNT_W-1:0] + CNT_W'(1));
      arm_rise = arm && !arm_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Match is tested before the arm drop so a simultaneous match still fires.
   always_comb begin
      state_d    = state_q;
      arm_load   = 1'b0;
      match_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm_rise) begin
               arm_load = 1'b1;
               state_d  = ARMED;
            end
         end
         ARMED: begin
            if (ext_q >= thr_q) begin
               match_load = 1'b1;
               state_d    = MATCH;
            end else if (!arm) begin
               state_d = IDLE;
            end
         end
         MATCH: begin
            if (evt_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_q     <= '0;
         thr_q     <= '0;
         evt_q     <= '0;
         ovf_q     <= 1'b0;
         skip_q    <= 1'b0;
         arm_q     <= 1'b0;
         evt_valid <= 1'b0;
      end else begin
         ext_q     <= ext_d;
         arm_q     <= arm;
         evt_valid <= (state_d == MATCH);
         if (arm_load) begin
            thr_q <= thresh;
         end
         if (match_load) begin
            evt_q <= ext_q;
         end
         // A wrap landing on the arming edge is kept rather than lost.
         if (wrap) begin
            ovf_q <= 1'b1;
         end else if (arm_load) begin
            ovf_q <= 1'b0;
         end
         if (step_bad && (state_q == ARMED)) begin
            skip_q <= 1'b1;
         end else if (arm_load) begin
            skip_q <= 1'b0;
         end
      end
   end

   assign ext_count = ext_q;
   assign evt_count = evt_q;
   assign overflow  = ovf_q;
   assign skip_err  = skip_q;
   assign state     = state_q;

endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 SHALL have parameter EXT_W, default 12: width of the extended count, minimum 5.
REQ-002 SHALL have port clk, input, 1: sampling clock.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port cnt_in, input, 4: ripple counter output, treated as asynchronous and possibly mid-ripple.
REQ-005 SHALL have port arm, input, 1: a rising edge arms a threshold match.
REQ-006 SHALL have port thresh, input, EXT_W: match threshold, captured on the arm rising edge.
REQ-007 SHALL have port ext_count, output, EXT_W: extended filtered count.
REQ-008 SHALL have port evt_valid, output, 1: match event pending.
REQ-009 SHALL have port evt_ready, input, 1: consumer accepts the event.
REQ-010 SHALL have port evt_count, output, EXT_W: ext_count captured at the match.
REQ-011 SHALL have port overflow, output, 1: sticky flag, ext_count wrapped.
REQ-012 SHALL have port skip_err, output, 1: sticky flag, accepted step was neither 0 nor +1 mod 16.
REQ-013 SHALL have port state, output, 2: FSM state, where IDLE=0, ARMED=1, MATCH=2.

Function
REQ-014 SHALL pass cnt_in through a two-flop synchronizer (s1, s2), followed by a history register s3 <= s2.
REQ-015 SHALL accept a new value (acc <= s2) only on an edge where s2 == s3 and s2 != acc, so transient ripple codes are rejected.
REQ-016 SHALL show a cnt_in value held stable across 4 consecutive clk edges on ext_count after the 4th edge.
REQ-017 SHALL drive ext_count[3:0] equal to acc.
REQ-018 SHALL increment ext_count[EXT_W-1:4] by 1, modulo 2^(EXT_W-4), on every acceptance where new acc < old acc (wrap 15->0).
REQ-019 SHALL set overflow when ext_count transitions from all-ones to 0; overflow is cleared only by an arm rising edge or reset.
REQ-020 SHALL set skip_err when an accepted value differs from old acc by other than +1 mod 16; skip_err is cleared only by an arm rising edge or reset.
REQ-021 SHALL detect an arm rising edge as arm=1 with the previous-cycle arm=0, using a registered arm.
REQ-022 SHALL, in IDLE, on an arm rising edge: capture thresh into thr_q, clear overflow and skip_err, and go to ARMED.
REQ-023 SHALL, in ARMED with arm=0, go to IDLE without an event.
REQ-024 SHALL, in ARMED with ext_count >= thr_q (unsigned), capture ext_count into evt_count and go to MATCH; the >= test is used so skipped values still match.
REQ-025 SHALL, in ARMED, give the match condition priority over arm=0 when both are true in the same cycle.
REQ-026 SHALL drive evt_valid=1 exactly in MATCH.
REQ-027 SHALL hold evt_count stable while evt_valid=1.
REQ-028 SHALL, on evt_valid && evt_ready, go to IDLE; re-arming requires a new arm rising edge.
REQ-029 SHALL ignore arm transitions while in MATCH and not record them as edges.
REQ-030 SHALL let ext_count keep tracking cnt_in in every state.
REQ-031 SHALL match immediately if thr_q <= ext_count at arming: MATCH follows on the next edge.
REQ-032 SHALL make evt_ready irrelevant outside MATCH.

Reset
REQ-033 SHALL, on reset assertion, asynchronously clear s1, s2, s3, acc, ext_count, thr_q, evt_count, overflow, skip_err and the arm register, and set state to IDLE, so evt_valid=0.
REQ-034 SHALL abort any pending event on a reset mid-operation, with no handshake required.
REQ-035 SHALL, after reset deassertion, report a nonzero cnt_in as a step from acc=0 (skip_err is only evaluated when armed, for the step where it occurs).

Structure
REQ-036 SHALL place the state enum (IDLE, ARMED, MATCH) and the EXT_W default constant in package ripple_mon_pkg.
REQ-037 SHALL implement REQ-014 and REQ-015 in sub-module ripple_sync_filter (ports clk, reset, cnt_in, acc_out, acc_upd).
REQ-038 SHALL keep all remaining logic in ripple_count_monitor, with no latches and one clock domain.

Verification
REQ-039 SHALL cover free-running count: cnt_in steps 0..15 then 0, each held 8 clk -> ext_count reaches 0x00F then 0x010, overflow=0, skip_err=0.
REQ-040 SHALL cover glitch rejection: cnt_in 7->5 for 1 clk -> 8 (ripple transient) -> acc goes 7->8 directly, 5 is never seen on ext_count, skip_err=0.
REQ-041 SHALL cover threshold with backpressure: arm rising, thresh=0x013, count up from 0 -> MATCH when ext_count=0x013, evt_count=0x013; evt_ready held 0 for 10 clk -> evt_valid and evt_count stable; ready=1 -> IDLE next edge.
REQ-042 SHALL cover skip plus immediate match: armed, thresh=0x005, acc 3 then jump to 9 -> skip_err=1, evt_count=0x009; arm with thresh=0x000 -> MATCH on the next edge.
REQ-043 SHALL cover wrap: force ext_count to 0xFFF by counting, then one more step -> ext_count=0x000, overflow=1; arm rising edge -> overflow=0.
REQ-044 SHALL cover reset mid-MATCH: assert reset while evt_valid=1 -> evt_valid=0, state=IDLE and all outputs 0 in the same cycle, without waiting for a clk edge.
